fft_stage_ctrl: RTL and testbench

Sequencing controller for the radix-2 in-place FFT datapath. Accepts N samples over a valid/ready handshake and issues their bit-reversed write addresses into ping-pong bank 0. It then drives LOG2N butterfly stages, each reading one bank and writing the other, generating the address pair and twiddle index for every butterfly. It sits between the sample source, the two dual-port RAM banks and the butterfly/twiddle-ROM pipeline, and flags completion and the bank holding the result.

---
 rtl/fft_stage_ctrl.sv | 151 +++++++++++++++
 tb/tb_fft_stage_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_ctrl.sv
// Sequencing controller for a radix-2 in-place FFT: bit-reversed sample load into
// bank 0, then LOG2N ping-pong butterfly stages with address/twiddle generation.
module fft_stage_ctrl #(
  parameter int N      = 8,
  parameter int LOG2N  = 3,
  parameter int BF_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ld_we,
  output logic [LOG2N-1:0] ld_addr,
  output logic             rd_en,
  output logic             rd_bank,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_idx,
  output logic             wr_en,
  output logic             wr_bank,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b,
  output logic             busy,
  output logic             done,
  output logic             res_bank
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam int               DW       = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
  localparam logic [DW-1:0]    DRN_LAST = DW'(BF_LAT - 1);
  localparam logic [LOG2N-1:0] ONE      = LOG2N'(1);
  localparam logic [LOG2N-1:0] STG_LAST = LOG2N'(LOG2N - 1);
  localparam int               DLW      = 2*LOG2N + 2;

  logic [1:0]       state;
  logic [LOG2N-1:0] ld_cnt;
  logic [LOG2N-1:0] stage;
  logic [LOG2N-2:0] bfly;
  logic [DW-1:0]    drn_cnt;
  logic             done_q;
  logic [DLW-1:0]   dl [BF_LAT];

  logic [LOG2N-1:0] bfly_x, mask, pos, base, addr_a, addr_b;

  assign busy     = (state != S_IDLE);
  assign done     = done_q;
  assign res_bank = (LOG2N % 2 == 1) ? 1'b1 : 1'b0;

  always_comb begin
    in_ready = (state == S_LOAD);
    ld_we    = in_ready & in_valid;
    ld_addr  = '0;
    if (ld_we) begin
      for (int unsigned i = 0; i < LOG2N; i++) ld_addr[i] = ld_cnt[LOG2N-1-i];
    end
  end

  // Butterfly b of stage s pairs a = grp*2^(s+1) + pos with a + 2^s.
  always_comb begin
    bfly_x = {1'b0, bfly};
    mask   = (ONE << stage) - ONE;
    pos    = bfly_x & mask;
    base   = (bfly_x >> stage) << (stage + ONE);
    addr_a = base | pos;
    addr_b = addr_a + (ONE << stage);
    rd_en  = (state == S_RUN);
    rd_bank   = '0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    tw_idx    = '0;
    if (rd_en) begin
      rd_bank   = stage[0];
      rd_addr_a = addr_a;
      rd_addr_b = addr_b;
      tw_idx    = pos[LOG2N-2:0] << (STG_LAST - stage);
    end
  end

  // Write-side delay line; runs every cycle so the last writes land during DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BF_LAT; i++) dl[i] <= '0;
    end else begin
      dl[0] <= {rd_en, rd_addr_a, rd_addr_b, rd_en & ~rd_bank};
      for (int unsigned i = 1; i < BF_LAT; i++) dl[i] <= dl[i-1];
    end
  end

  assign wr_en     = dl[BF_LAT-1][DLW-1];
  assign wr_addr_a = dl[BF_LAT-1][DLW-2 -: LOG2N];
  assign wr_addr_b = dl[BF_LAT-1][LOG2N:1];
  assign wr_bank   = dl[BF_LAT-1][0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      ld_cnt  <= '0;
      stage   <= '0;
      bfly    <= '0;
      drn_cnt <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_LOAD;
            ld_cnt  <= '0;
            stage   <= '0;
            bfly    <= '0;
            drn_cnt <= '0;
          end
        end
        S_LOAD: begin
          if (ld_we) begin
            ld_cnt <= ld_cnt + ONE;
            if (&ld_cnt) state <= S_RUN;
          end
        end
        S_RUN: begin
          bfly <= bfly + (LOG2N-1)'(1);
          if (&bfly) begin
            bfly    <= '0;
            drn_cnt <= '0;
            state   <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          drn_cnt <= drn_cnt + DW'(1);
          if (drn_cnt == DRN_LAST) begin
            drn_cnt <= '0;
            if (stage == STG_LAST) begin
              state  <= S_IDLE;
              done_q <= 1'b1;
            end else begin
              stage <= stage + ONE;
              state <= S_RUN;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Randomized self-checking bench for fft_stage_ctrl against an arithmetic schedule model.
module tb_fft_stage_ctrl;
  localparam int N       = 8;
  localparam int LOG2N   = 3;
  localparam int BF_LAT  = 2;
  localparam int HALFN   = N / 2;
  localparam int STG_CYC = HALFN + BF_LAT;
  localparam int TOTAL   = LOG2N * STG_CYC + 1;

  logic clk = 1'b0;
  logic rst, start, in_valid;
  logic in_ready, ld_we, rd_en, rd_bank, wr_en, wr_bank, busy, done, res_bank;
  logic [LOG2N-1:0] ld_addr, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [LOG2N-2:0] tw_idx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fft_stage_ctrl #(.N(N), .LOG2N(LOG2N), .BF_LAT(BF_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .ld_we(ld_we), .ld_addr(ld_addr),
    .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .tw_idx(tw_idx), .wr_en(wr_en), .wr_bank(wr_bank),
    .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .busy(busy), .done(done), .res_bank(res_bank)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int bitrev(input int x);
    int r = 0;
    int v = x;
    for (int i = 0; i < LOG2N; i++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  // Expected read in cycle k after the last load accept (k = 1 is the first RUN cycle).
  task automatic exp_read(input int k, output bit vld, output int a, output int b,
                          output int tw, output int bank);
    int s, off, half;
    s    = (k - 1) / STG_CYC;
    off  = (k - 1) % STG_CYC;
    vld  = (k >= 1) && (k <= LOG2N * STG_CYC) && (off < HALFN);
    half = 2 ** s;
    a    = (off / half) * 2 * half + off % half;
    b    = a + half;
    tw   = (off % half) * (N / (2 * half));
    bank = s % 2;
  endtask

  // mode 0: full rate, 1: one 3-cycle gap, 2: random valid
  task automatic do_load(input bit do_start, input int mode);
    int cnt = 0, cyc = 0, gap_at, gap_left = 3;
    bit v;
    gap_at = $urandom_range(1, N - 2);
    if (do_start) begin
      start = 1'b1;
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    while (cnt < N && cyc < 200) begin
      if (mode == 1 && cnt == gap_at && gap_left > 0) begin
        v = 1'b0;
        gap_left--;
      end else if (mode == 2) v = ($urandom_range(0, 3) != 0);
      else v = 1'b1;
      in_valid = v;
      start = $urandom_range(0, 1);
      @(negedge clk);
      check("load_in_ready", in_ready, 1);
      check("load_busy", busy, 1);
      check("load_rd_en", rd_en, 0);
      check("ld_we", ld_we, v);
      if (v) check("ld_addr", ld_addr, bitrev(cnt));
      @(posedge clk); #1;
      if (v) cnt++;
      cyc++;
    end
    if (cnt < N) check("load_timeout", cnt, N);
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  // Checks every cycle of the stage sequence; abort_k > 0 asserts reset during that cycle.
  task automatic do_run(input int drain_start_k, input bit chain, input int abort_k);
    bit rv, wv;
    int ra, rb, rt, rk, wa, wb, wt, wk;
    for (int k = 1; k <= TOTAL; k++) begin
      start = (k == drain_start_k) || (chain && k == TOTAL);
      if (k == abort_k) rst = 1'b1;
      @(negedge clk);
      exp_read(k, rv, ra, rb, rt, rk);
      exp_read(k - BF_LAT, wv, wa, wb, wt, wk);
      check("rd_en", rd_en, rv);
      if (rv) begin
        check("rd_addr_a", rd_addr_a, ra);
        check("rd_addr_b", rd_addr_b, rb);
        check("tw_idx", tw_idx, rt);
        check("rd_bank", rd_bank, rk);
      end
      check("wr_en", wr_en, wv);
      if (wv) begin
        check("wr_addr_a", wr_addr_a, wa);
        check("wr_addr_b", wr_addr_b, wb);
        check("wr_bank", wr_bank, 1 - wk);
      end
      check("run_in_ready", in_ready, 0);
      check("run_busy", busy, k < TOTAL);
      check("done", done, k == TOTAL);
      @(posedge clk); #1;
      if (k == abort_k) break;
    end
    start = 1'b0;
    if (abort_k > 0) begin
      rst = 1'b0;
      @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_rd_en", rd_en, 0);
      check("abort_wr_en", wr_en, 0);
      check("abort_in_ready", in_ready, 0);
      for (int i = 0; i < TOTAL + 4; i++) begin
        @(negedge clk);
        check("abort_no_done", done, 0);
        check("abort_wr_quiet", wr_en, 0);
      end
      @(posedge clk); #1;
    end else if (!chain) begin
      @(negedge clk);
      check("post_done", done, 0);
      check("post_busy", busy, 0);
      check("post_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
  endtask

  function automatic int drain_cycle();
    return $urandom_range(0, LOG2N - 1) * STG_CYC + HALFN + 1 + $urandom_range(0, BF_LAT - 1);
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_ld_we", ld_we, 0);
    check("rst_ld_addr", ld_addr, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr_a", rd_addr_a, 0);
    check("rst_rd_addr_b", rd_addr_b, 0);
    check("rst_tw_idx", tw_idx, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("res_bank", res_bank, LOG2N % 2);
    @(posedge clk); #1;

    do_load(1'b1, 0); do_run(drain_cycle(), 1'b0, 0);
    do_load(1'b1, 1); do_run(drain_cycle(), 1'b1, 0);
    do_load(1'b0, 2); do_run(drain_cycle(), 1'b0, 0);
    do_load(1'b1, 0); do_run(0, 1'b0, 1 + STG_CYC + 2);
    do_load(1'b1, 0); do_run(0, 1'b0, 0);
    for (int t = 0; t < 4; t++) begin
      do_load(1'b1, $urandom_range(0, 2));
      do_run(drain_cycle(), 1'b0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
